instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//   Fetch side of the opcode interface: produces the 3-bit operation consumed by control.
//   Holds the PC and issues one read at a time to instruction memory over a req/ack handshake.
//   Presents each fetched word to decode with a valid/ready handshake.
//   Takes PC redirects (jump / taken branch) from execute.
// PARAMETERS
//   ADDR_W   8       instruction address width; PC wraps modulo 2**ADDR_W
//   INSTR_W  16      instruction width; opcode = instr[INSTR_W-1 -: 3]
//   RESET_PC 0       PC value loaded on reset
// PORTS
//   clk           in   1        clock, all state on rising edge
//   reset         in   1        synchronous, active-high
//   imem_req      out  1        read request to instruction memory
//   imem_addr     out  ADDR_W   read address, stable while imem_req=1
//   imem_ack      in   1        read complete; imem_rdata valid this cycle
//   imem_rdata    in   INSTR_W  read data
//   instr_valid   out  1        instr/operation valid to decode
//   instr_ready   in   1        decode accepts instruction
//   instr         out  INSTR_W  fetched instruction word
//   operation     out  3        opcode field to control; 3'b000 when instr_valid=0
//   instr_pc      out  ADDR_W   address the current instr was fetched from
//   redirect_valid in  1        one-cycle pulse: change PC (jump or branch taken)
//   redirect_pc   in   ADDR_W   redirect target
//   halted        out  1        fetch stopped on HALT opcode (see CONFIGURATION)
// BEHAVIOUR
//   Reset: pc=RESET_PC, state=FETCH, instr_valid=0, instr=0, instr_pc=0, halted=0,
//     redir_pend=0. While reset=1, imem_req=0. Reset mid-transaction abandons everything.
//   imem_req = (state==FETCH) & ~reset; imem_addr = pc (registered, never changes while req=1).
//   FETCH: hold req until imem_ack. On ack (no pending redirect):
//     instr<=imem_rdata, instr_pc<=pc, pc<=pc+1 (wrap), instr_valid<=1 -> ISSUE.
//     Ack in the same cycle as first req is legal.
//     Fetch-to-valid latency is 1 cycle after ack.
//   ISSUE: instr_valid=1. instr, operation and instr_pc stay stable until instr_ready=1.
//     No memory request is made. On valid&ready: instr_valid<=0 -> FETCH.
//     Peak throughput is 1 instruction per 2 cycles.
//   Redirect has priority over all other events:
//     ISSUE or HALTED: pc<=redirect_pc, instr_valid<=0 -> FETCH. A simultaneous ready counts
//       as a completed handshake.
//     FETCH with imem_ack the same cycle: rdata is discarded, pc<=redirect_pc, stay FETCH.
//     FETCH without ack: latch redir_pend=1 and redir_tgt. Keep req/addr unchanged.
//       On ack: discard rdata, pc<=redir_tgt, clear redir_pend, stay FETCH.
//       A second redirect while pending overwrites redir_tgt.
//   imem_ack outside FETCH is ignored.
//   FSM states: FETCH, ISSUE, HALTED. HALTED exists only with the macro.
// CONFIGURATION
//   IFU_HALT_DETECT_EN defined:
//     Handshake of opcode 3'b111 -> HALTED (halted=1, imem_req=0, instr_valid=0); pc already
//       points past the halt.
//     HALTED exits only on redirect (-> FETCH, halted<=0) or reset.
//   Undefined: 3'b111 is an ordinary opcode, HALTED is unreachable, halted tied to 0.
// TESTING
//   1 Reset release: imem_req=1, addr=0x00.
//     Ack with rdata=16'h4123 -> next cycle instr_valid=1, operation=3'b010,
//     instr_pc=0x00, pc=0x01.
//   2 Backpressure: instr_ready=0 for 3 cycles -> instr and operation stable, imem_req=0.
//     Ready=1 -> instr_valid=0, req for 0x01 next cycle.
//   3 Redirect mid-fetch: ack delayed 2 cycles, redirect_pc=0x40 pulsed during wait.
//     -> addr holds 0x00, data dropped with no instr_valid, next req addr=0x40.
//   4 Wrap: pc=0xFF fetched and accepted -> next imem_addr=0x00.
//   5 Reset asserted during ISSUE -> next cycle instr_valid=0, operation=0.
//     After release, req addr=RESET_PC.
//   6 (macro on) Word 16'hE000 accepted -> halted=1, imem_req=0 for 10 cycles.
//     Redirect 0x10 -> halted=0, req addr=0x10.
//     Macro off: same word -> normal fetch continues.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bundle: instruction-memory read port (req/ack), decode issue port (valid/ready),
// and the execute redirect input. The fetch unit uses master; memory/decode/execute use slave.
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [2:0]         operation;
  logic [ADDR_W-1:0]  instr_pc;

  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;

  logic               halted;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, operation, instr_pc, halted,
    input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, operation, instr_pc, halted,
    output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch: one imem read, instr valid 1 cycle after ack, held until decode ready
// (no request while an instruction waits); redirects win over everything. IFU_HALT_DETECT_EN adds the HALTED stop.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_fetch_unit_if.master   bus
);

`ifdef IFU_HALT_DETECT_EN
  typedef enum logic [1:0] {FETCH = 2'd0, ISSUE = 2'd1, HALTED = 2'd2} state_e;
  localparam logic [2:0] OP_HALT = 3'b111;
`else
  typedef enum logic [1:0] {FETCH = 2'd0, ISSUE = 2'd1} state_e;
`endif

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e              state_q,      state_d;
  logic [ADDR_W-1:0]   pc_q,         pc_d;
  logic [INSTR_W-1:0]  instr_q,      instr_d;
  logic [ADDR_W-1:0]   instr_pc_q,   instr_pc_d;
  logic                redir_pend_q, redir_pend_d;
  logic [ADDR_W-1:0]   redir_tgt_q,  redir_tgt_d;

  logic [2:0]          opcode;

  assign opcode = instr_q[INSTR_W-1 -: 3];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;

    case (state_q)
      FETCH: begin
        // The address must not move while req is up, so a redirect without ack waits for the read to drain.
        if (bus.redirect_valid) begin
          if (bus.imem_ack) begin
            pc_d         = bus.redirect_pc;
            redir_pend_d = 1'b0;
          end else begin
            redir_pend_d = 1'b1;
            redir_tgt_d  = bus.redirect_pc;
          end
        end else if (bus.imem_ack) begin
          if (redir_pend_q) begin
            pc_d         = redir_tgt_q;
            redir_pend_d = 1'b0;
          end else begin
            instr_d    = bus.imem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + PC_ONE;
            state_d    = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_pc;
          state_d = FETCH;
        end else if (bus.instr_ready) begin
          state_d = FETCH;
`ifdef IFU_HALT_DETECT_EN
          if (opcode == OP_HALT) begin
            state_d = HALTED;
          end
`endif
        end
      end

`ifdef IFU_HALT_DETECT_EN
      HALTED: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_pc;
          state_d = FETCH;
        end
      end
`endif

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
    end
  end

  assign bus.imem_req    = (state_q == FETCH) & ~reset;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == ISSUE);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.operation   = (state_q == ISSUE) ? opcode : 3'b000;

`ifdef IFU_HALT_DETECT_EN
  assign bus.halted = (state_q == HALTED);
`else
  assign bus.halted = 1'b0;
`endif

endmodule
